// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo scheduling types: dispatch FSM encoding, default widths and
// the wrap-safe issue-tag comparison used by the dispatch arbiters.
package tomasulo_pkg;

  localparam int unsigned DEF_N_RS   = 4;
  localparam int unsigned DEF_AGE_W  = 10;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_OP_W   = 3;
  localparam int unsigned DEF_ID_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEL   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } disp_state_t;

  // a is older than b when b sits less than half the tag ring ahead of a
  function automatic logic age_older(input logic [31:0] a, input logic [31:0] b,
                                     input int unsigned aw);
    logic [31:0] mask;
    logic [31:0] diff;
    mask = (aw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << aw) - 32'd1);
    diff = (b - a) & mask;
    return (diff != 32'd0) && (diff < (32'd1 << (aw - 1)));
  endfunction

endpackage

// File: rtl/oldest_select.sv
// Combinational oldest-ready selection across N_RS stations; equal tags keep
// the lowest index because a later station must be strictly older to win.
module oldest_select
  import tomasulo_pkg::*;
#(
  parameter int N_RS  = DEF_N_RS,
  parameter int AGE_W = DEF_AGE_W,
  parameter int IDX_W = (N_RS > 1) ? $clog2(N_RS) : 1
) (
  input  logic [N_RS-1:0]       i_ready,
  input  logic [N_RS*AGE_W-1:0] i_age,
  output logic [IDX_W-1:0]      o_win_idx,
  output logic                  o_valid
);

  logic             w_best_v;
  logic [AGE_W-1:0] w_best_age;
  logic [IDX_W-1:0] w_best_idx;

  always_comb begin
    w_best_v   = 1'b0;
    w_best_age = '0;
    w_best_idx = '0;
    for (int k = 0; k < N_RS; k++) begin
      if (i_ready[k] &&
          (!w_best_v || age_older(32'(i_age[k*AGE_W +: AGE_W]), 32'(w_best_age), AGE_W))) begin
        w_best_v   = 1'b1;
        w_best_age = i_age[k*AGE_W +: AGE_W];
        w_best_idx = IDX_W'(k);
      end
    end
  end

  assign o_win_idx = w_best_idx;
  assign o_valid   = w_best_v;

endmodule

// File: rtl/rs_dispatch_arbiter.sv
// Issues the oldest ready add/sub reservation station to the shared UA, one op
// in flight. Optional DISP_STALL_CNT_EN adds a saturating stall_cnt output.
//
// state    | meaning
// ST_IDLE  | scanning requests, nothing latched for issue
// ST_SEL   | winner and operands latched, winner request re-checked
// ST_ISSUE | waiting for !fu_busy, then start + grant pulse
// ST_WAIT  | op in flight until fu_done
module rs_dispatch_arbiter
  import tomasulo_pkg::*;
#(
  parameter int N_RS   = DEF_N_RS,
  parameter int AGE_W  = DEF_AGE_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W,
  parameter int ID_W   = DEF_ID_W
) (
  input  logic                   CLK,
  input  logic                   CLR,
  input  logic [N_RS-1:0]        rs_ready,
  input  logic [N_RS*AGE_W-1:0]  rs_age,
  input  logic [N_RS*DATA_W-1:0] rs_val1,
  input  logic [N_RS*DATA_W-1:0] rs_val2,
  input  logic [N_RS*OP_W-1:0]   rs_op,
  input  logic [N_RS*ID_W-1:0]   rs_id,
  output logic [N_RS-1:0]        rs_grant,
  input  logic                   fu_busy,
  input  logic                   fu_done,
  output logic                   fu_start,
  output logic [DATA_W-1:0]      fu_val1,
  output logic [DATA_W-1:0]      fu_val2,
  output logic [OP_W-1:0]        fu_op,
  output logic [ID_W-1:0]        fu_id,
  output logic                   inflight
`ifdef DISP_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int IDX_W = (N_RS > 1) ? $clog2(N_RS) : 1;

  disp_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0]  w_win_idx, r_win;
  logic              w_win_valid;
  logic [DATA_W-1:0] r_val1, r_val2;
  logic [OP_W-1:0]   r_op;
  logic [ID_W-1:0]   r_id;
  logic              r_inflight;

  oldest_select #(.N_RS(N_RS), .AGE_W(AGE_W), .IDX_W(IDX_W)) u_oldest_select (
    .i_ready  (rs_ready),
    .i_age    (rs_age),
    .o_win_idx(w_win_idx),
    .o_valid  (w_win_valid)
  );

  always_ff @(posedge CLK) begin
    if (CLR) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_win_valid && !fu_busy) w_state_nxt = ST_SEL;
      ST_SEL:   w_state_nxt = rs_ready[r_win] ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: if (!fu_busy) w_state_nxt = ST_WAIT;
      ST_WAIT:  if (fu_done) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    fu_start = (r_state == ST_ISSUE) && !fu_busy;
    rs_grant = '0;
    if (fu_start) rs_grant[r_win] = 1'b1;
  end

  // Operands are captured only on the IDLE->SEL edge so they stay stable through WAIT
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_win      <= '0;
      r_val1     <= '0;
      r_val2     <= '0;
      r_op       <= '0;
      r_id       <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_state_nxt == ST_SEL) begin
        r_win  <= w_win_idx;
        r_val1 <= rs_val1[w_win_idx*DATA_W +: DATA_W];
        r_val2 <= rs_val2[w_win_idx*DATA_W +: DATA_W];
        r_op   <= rs_op[w_win_idx*OP_W +: OP_W];
        r_id   <= rs_id[w_win_idx*ID_W +: ID_W];
      end
      if (fu_start)                          r_inflight <= 1'b1;
      else if (r_state == ST_WAIT && fu_done) r_inflight <= 1'b0;
    end
  end

  assign fu_val1  = r_val1;
  assign fu_val2  = r_val2;
  assign fu_op    = r_op;
  assign fu_id    = r_id;
  assign inflight = r_inflight;

`ifdef DISP_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge CLK) begin
    if (CLR) r_stall_cnt <= '0;
    else if ((|rs_ready) && !fu_start && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
